nano_int_ctrl: RTL and testbench

- Interrupt controller for the Nano MCU system.
- Synchronizes the external interrupt lines EINT0..EINT2 and detects rising edges on them.
- Latches each event as pending, applies a CPU-written mask, and picks one winner to present to the CPU core over an IRQ/ACK/RET handshake with a vector.
- Sits between the top-level pads (uio_in[6:4]) and the CPU; no nesting, one interrupt in service at a time.

---
 rtl/nano_int_pkg.sv | 15 +
 rtl/nano_int_ctrl_if.sv | 31 +++
 rtl/nano_int_sync_edge.sv | 33 +++
 rtl/nano_int_ctrl.sv | 153 +++++++++++++++
 tb/tb_nano_int_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nano_int_pkg.sv
// Shared types and constants for the Nano MCU interrupt controller.
package nano_int_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_e;

  localparam int unsigned ID_W  = 2;
  localparam int unsigned VEC_W = 4;

  localparam logic [VEC_W-1:0] VEC_BASE_DEF = 4'h8;

endpackage

// File: rtl/nano_int_ctrl_if.sv
// CPU/pad-facing signal bundle of the interrupt controller.
// master = CPU and pad side, slave = controller.
interface nano_int_ctrl_if #(
  parameter int unsigned NUM_INT = 3
);
  import nano_int_pkg::*;

  logic [NUM_INT-1:0] EINT;
  logic               GIE;
  logic               MASK_WE;
  logic [NUM_INT-1:0] MASK_DIN;
  logic [NUM_INT-1:0] MASK;
  logic [NUM_INT-1:0] PEND;
  logic               IRQ;
  logic               INT_ACK;
  logic               INT_RET;
  logic               IN_SVC;
  logic [ID_W-1:0]    ID;
  logic [VEC_W-1:0]   VEC;

  modport master (
    output EINT, GIE, MASK_WE, MASK_DIN, INT_ACK, INT_RET,
    input  MASK, PEND, IRQ, IN_SVC, ID, VEC
  );

  modport slave (
    input  EINT, GIE, MASK_WE, MASK_DIN, INT_ACK, INT_RET,
    output MASK, PEND, IRQ, IN_SVC, ID, VEC
  );

endinterface

// File: rtl/nano_int_sync_edge.sv
// Per-line synchronizer plus registered, arm-gated rising-edge pulse.
module nano_int_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  input  logic i_arm,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
      r_rise <= i_arm & w_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/nano_int_ctrl.sv
// Interrupt controller: edge capture, pending/mask, arbitration, IRQ/ACK/RET FSM.
// Define NANO_INT_RR_PRIO_EN for rotating priority; default is fixed (line 0 highest).
module nano_int_ctrl
  import nano_int_pkg::*;
#(
  parameter int unsigned      NUM_INT     = 3,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [VEC_W-1:0] VEC_BASE    = VEC_BASE_DEF
) (
  input logic             CLK,
  input logic             RST,
  nano_int_ctrl_if.slave  bus
);

  localparam int unsigned ARM_CYC = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_CYC + 1);

  logic [ARM_W-1:0]   r_arm_cnt;
  logic               w_armed;
  logic [NUM_INT-1:0] w_rise;
  logic [NUM_INT-1:0] r_pend;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] w_elig;
  logic [NUM_INT-1:0] w_clr;
  logic               w_any;
  logic               w_ack_ok;
  logic [ID_W-1:0]    w_win;
  state_e             r_state;
  logic               r_irq;
  logic               r_in_svc;
  logic [ID_W-1:0]    r_id;
  logic [VEC_W-1:0]   r_vec;

  // Hold off edge detection until the sync chains carry post-reset samples.
  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYC));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_INT; g++) begin : g_line
    nano_int_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .CLK    (CLK),
      .RST    (RST),
      .i_async(bus.EINT[g]),
      .i_arm  (w_armed),
      .o_rise (w_rise[g])
    );
  end

  assign w_elig   = r_pend & r_mask & {NUM_INT{bus.GIE}};
  assign w_any    = |w_elig;
  assign w_ack_ok = (r_state == REQ) & bus.INT_ACK & w_any;
  assign w_clr    = w_ack_ok ? (NUM_INT'(1) << w_win) : '0;

`ifdef NANO_INT_RR_PRIO_EN
  logic [ID_W-1:0] r_ptr;

  // Descending scan so the index closest to the pointer is assigned last.
  always_comb begin
    w_win = '0;
    for (int j = 0; j < NUM_INT; j++) begin
      if (r_ptr == ID_W'(j)) begin
        for (int i = NUM_INT - 1; i >= 0; i--) begin
          if (w_elig[(i + j) % NUM_INT]) w_win = ID_W'((i + j) % NUM_INT);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (w_ack_ok) begin
      r_ptr <= (w_win == ID_W'(NUM_INT - 1)) ? '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end
`endif

  // A new edge in the same cycle as the ACK clear must survive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask <= '0;
      r_pend <= '0;
    end else begin
      if (bus.MASK_WE) r_mask <= bus.MASK_DIN;
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_irq    <= 1'b0;
      r_in_svc <= 1'b0;
      r_id     <= '0;
      r_vec    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= REQ;
            r_irq   <= 1'b1;
          end
        end
        REQ: begin
          if (w_ack_ok) begin
            r_state  <= SVC;
            r_irq    <= 1'b0;
            r_in_svc <= 1'b1;
            r_id     <= w_win;
            r_vec    <= VEC_BASE + VEC_W'(w_win);
          end else if (!w_any) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end
        end
        SVC: begin
          if (bus.INT_RET) begin
            r_state  <= IDLE;
            r_in_svc <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_irq    <= 1'b0;
          r_in_svc <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MASK   = r_mask;
  assign bus.PEND   = r_pend;
  assign bus.IRQ    = r_irq;
  assign bus.IN_SVC = r_in_svc;
  assign bus.ID     = r_id;
  assign bus.VEC    = r_vec;

endmodule

// File: tb/tb_nano_int_ctrl.sv
// Directed bench for nano_int_ctrl with a cycle-level reference model and per-cycle compare.
module tb_nano_int_ctrl;

`ifdef NANO_INT_RR_PRIO_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  nano_int_ctrl_if #(.NUM_INT(3)) bus ();

  nano_int_ctrl #(
    .NUM_INT    (3),
    .SYNC_STAGES(2),
    .VEC_BASE   (4'h8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 requesting, 2 in service.
  int         m_state = 0;
  int         m_ptr   = 0;
  logic [2:0] m_pend  = '0;
  logic [2:0] m_mask  = '0;
  logic [1:0] m_id    = '0;
  logic [3:0] m_vec   = '0;

  initial begin
    logic [2:0] s_prev;
    logic [2:0] rq0, rq1, rq2;
    logic [2:0] rise, elig, clr, set_now;
    bit         prev_valid;
    int         win;
    int         k;
    s_prev = '0; rq0 = '0; rq1 = '0; rq2 = '0; prev_valid = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = 0; m_ptr = 0; m_pend = '0; m_mask = '0; m_id = '0; m_vec = '0;
        s_prev = '0; rq0 = '0; rq1 = '0; rq2 = '0; prev_valid = 0;
      end else begin
        // A rise between two post-reset samples shows up on PEND three edges later.
        rise       = prev_valid ? (bus.EINT & ~s_prev) : 3'b000;
        s_prev     = bus.EINT;
        prev_valid = 1;
        set_now    = rq2;
        rq2        = rq1;
        rq1        = rq0;
        rq0        = rise;
        elig       = m_pend & m_mask & {3{bus.GIE}};
        win        = 0;
        for (int i = 2; i >= 0; i--) begin
          k = (m_ptr + i) % 3;
          if (((elig >> k) & 3'b001) != 3'b000) win = k;
        end
        clr = 3'b000;
        case (m_state)
          0: if (elig != 3'b000) m_state = 1;
          1: begin
            if (bus.INT_ACK && elig != 3'b000) begin
              m_state = 2;
              m_id    = 2'(win);
              m_vec   = 4'h8 + 4'(win);
              clr     = 3'b001 << win;
              if (RR == 1) m_ptr = (win + 1) % 3;
            end else if (elig == 3'b000) begin
              m_state = 0;
            end
          end
          default: if (bus.INT_RET) m_state = 0;
        endcase
        m_pend = (m_pend & ~clr) | set_now;
        if (bus.MASK_WE) m_mask = bus.MASK_DIN;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp("model_pend", int'(bus.PEND), int'(m_pend));
      cmp("model_mask", int'(bus.MASK), int'(m_mask));
      cmp("model_irq", int'(bus.IRQ), (m_state == 1) ? 1 : 0);
      cmp("model_in_svc", int'(bus.IN_SVC), (m_state == 2) ? 1 : 0);
      cmp("model_id", int'(bus.ID), int'(m_id));
      cmp("model_vec", int'(bus.VEC), int'(m_vec));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus.INT_ACK = 1'b1; cyc(1); bus.INT_ACK = 1'b0;
  endtask

  task automatic ret_pulse();
    bus.INT_RET = 1'b1; cyc(1); bus.INT_RET = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int max_cyc);
    int n = 0;
    while (bus.IRQ !== 1'b1 && n < max_cyc) begin
      cyc(1);
      n++;
    end
    cmp(name, int'(bus.IRQ), 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.EINT = 3'b111; bus.GIE = 1'b0; bus.MASK_WE = 1'b0; bus.MASK_DIN = 3'b000;
    bus.INT_ACK = 1'b0; bus.INT_RET = 1'b0;
    cyc(3);
    cmp("rst_mask", int'(bus.MASK), 0);
    cmp("rst_irq", int'(bus.IRQ), 0);
    rst = 1'b0;
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 3'b111; cyc(1); bus.MASK_WE = 1'b0; bus.GIE = 1'b1;
    cyc(20);
    cmp("arm_pend", int'(bus.PEND), 0);
    cmp("arm_irq", int'(bus.IRQ), 0);
    cmp("mask_load", int'(bus.MASK), 7);
    bus.EINT = 3'b000; cyc(4);

    // Single edge on line 1: PEND after three edges, IRQ one later.
    bus.EINT = 3'b010; cyc(3);
    cmp("lat_pend_early", int'(bus.PEND), 0);
    cyc(1);
    cmp("lat_pend", int'(bus.PEND), 2);
    cmp("lat_irq_early", int'(bus.IRQ), 0);
    bus.EINT = 3'b000; cyc(1);
    cmp("lat_irq", int'(bus.IRQ), 1);
    ack_pulse();
    cmp("ack1_id", int'(bus.ID), 1);
    cmp("ack1_vec", int'(bus.VEC), 'h9);
    cmp("ack1_pend", int'(bus.PEND), 0);
    cmp("ack1_in_svc", int'(bus.IN_SVC), 1);
    cmp("ack1_irq", int'(bus.IRQ), 0);
    cyc(2); ret_pulse();
    cmp("ret1_in_svc", int'(bus.IN_SVC), 0);
    cyc(3);
    cmp("ret1_irq", int'(bus.IRQ), 0);
    cmp("ret1_id_hold", int'(bus.ID), 1);

    // Simultaneous edges on lines 0 and 2.
    bus.EINT = 3'b101; cyc(4);
    cmp("dual_pend", int'(bus.PEND), 5);
    bus.EINT = 3'b000;
    wait_irq("dual_irq", 3);
    ack_pulse();
    cmp("dual_id0", int'(bus.ID), 0);
    cmp("dual_vec0", int'(bus.VEC), 'h8);
    cmp("dual_pend_left", int'(bus.PEND), 4);
    cyc(1); ret_pulse();
    wait_irq("dual_reirq", 3);
    ack_pulse();
    cmp("dual_id2", int'(bus.ID), 2);
    cmp("dual_vec2", int'(bus.VEC), 'hA);
    ret_pulse(); cyc(2);

    // Line 0 re-pends in service alongside line 2; priority mode picks the next winner.
    bus.EINT = 3'b101; cyc(4); bus.EINT = 3'b000;
    wait_irq("prio_irq", 3);
    ack_pulse();
    cmp("prio_id_first", int'(bus.ID), 0);
    bus.EINT = 3'b001; cyc(4);
    cmp("svc_pend", int'(bus.PEND), 5);
    cmp("svc_irq", int'(bus.IRQ), 0);
    bus.EINT = 3'b000;
    ret_pulse();
    wait_irq("ret_irq_2cyc", 2);
    ack_pulse();
    cmp("prio_id_second", int'(bus.ID), (RR == 1) ? 2 : 0);
    cmp("prio_vec_second", int'(bus.VEC), (RR == 1) ? 'hA : 'h8);
    ret_pulse();
    wait_irq("prio_irq_third", 3);
    ack_pulse();
    cmp("prio_id_third", int'(bus.ID), (RR == 1) ? 0 : 2);
    ret_pulse(); cyc(2);

    // Mask write while requesting drops IRQ and keeps PEND.
    bus.EINT = 3'b010; cyc(4); bus.EINT = 3'b000;
    wait_irq("mask_irq", 3);
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 3'b000; cyc(1); bus.MASK_WE = 1'b0;
    cmp("mask_zero", int'(bus.MASK), 0);
    cmp("mask_irq_hold", int'(bus.IRQ), 1);
    cyc(1);
    cmp("mask_irq_drop", int'(bus.IRQ), 0);
    cmp("mask_pend_kept", int'(bus.PEND), 2);
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 3'b111; cyc(1); bus.MASK_WE = 1'b0; cyc(1);
    cmp("mask_reirq", int'(bus.IRQ), 1);

    // Fresh edge on line 1 lands on the same edge as the ACK that clears it.
    bus.EINT = 3'b010; cyc(3);
    bus.INT_ACK = 1'b1; cyc(1); bus.INT_ACK = 1'b0;
    cmp("set_wins_pend", int'(bus.PEND), 2);
    cmp("set_wins_in_svc", int'(bus.IN_SVC), 1);
    cmp("set_wins_id", int'(bus.ID), 1);
    bus.EINT = 3'b000;
    ret_pulse();
    wait_irq("set_wins_reirq", 3);
    ack_pulse();
    cmp("set_wins_clear", int'(bus.PEND), 0);
    ret_pulse(); cyc(2);

    // GIE low while requesting drops IRQ.
    bus.EINT = 3'b010; cyc(4); bus.EINT = 3'b000;
    wait_irq("gie_irq", 3);
    bus.GIE = 1'b0; cyc(2);
    cmp("gie_irq_drop", int'(bus.IRQ), 0);
    cmp("gie_pend_kept", int'(bus.PEND), 2);
    bus.GIE = 1'b1;
    wait_irq("gie_reirq", 3);
    ack_pulse();

    // Reset in service with line 2 pending.
    bus.EINT = 3'b100; cyc(4); bus.EINT = 3'b000;
    cmp("pre_rst_pend", int'(bus.PEND), 4);
    cmp("pre_rst_in_svc", int'(bus.IN_SVC), 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    cmp("post_rst_irq", int'(bus.IRQ), 0);
    cmp("post_rst_in_svc", int'(bus.IN_SVC), 0);
    cmp("post_rst_pend", int'(bus.PEND), 0);
    cmp("post_rst_mask", int'(bus.MASK), 0);
    cmp("post_rst_id", int'(bus.ID), 0);
    cmp("post_rst_vec", int'(bus.VEC), 0);
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
